// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: 4-master AHB round-robin bus arbiter with locked-transfer
// and ERROR handling. Optional tenure limit that bounds how long an owner can
// hold the bus while others wait; enabled by defining AHB_ARB_TENURE_LIMIT_EN.
//
// state | meaning
// PARK  | no requests; master 0 granted by default
// OWN   | bus granted to a requesting master
// LOCK  | owner holds a locked sequence; grant frozen

module ahb_rr_arbiter #(
   parameter int TENURE_MAX = 16
) (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic [3:0] hbusreq,
   input  logic [3:0] hlock,
   input  logic [1:0] htrans,
   input  logic       hready,
   input  logic       hresp,
   output logic [3:0] hgrant,
   output logic [1:0] hmaster,
   output logic [1:0] hmaster_data,
   output logic       hmastlock
);

   localparam logic [1:0] ST_PARK = 2'd0;
   localparam logic [1:0] ST_OWN  = 2'd1;
   localparam logic [1:0] ST_LOCK = 2'd2;

   localparam logic [1:0] HTRANS_SEQ = 2'b11;

   logic [1:0] state;
   logic [1:0] rr_ptr;
   logic       force_arb;
   logic [1:0] owner_idx;
   logic [1:0] pick_idx;
   logic       pick_valid;
   logic       arb_pt;
   logic       err_first;
   logic       tenure_hit;
   logic [3:0] grant_nxt;

   // Index of the currently granted master
   always_comb begin
      owner_idx = 2'd0;
      unique case (hgrant)
         4'b0010: owner_idx = 2'd1;
         4'b0100: owner_idx = 2'd2;
         4'b1000: owner_idx = 2'd3;
         default: owner_idx = 2'd0;
      endcase
   end

   // Round-robin search from rr_ptr+1, the last owner is considered last
   always_comb begin
      logic [1:0] cand;
      cand       = 2'd0;
      pick_valid = 1'b0;
      pick_idx   = rr_ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = rr_ptr + 2'(k);
         if (!pick_valid && hbusreq[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Arbitration point qualification and next grant
   always_comb begin
      err_first = hresp && !hready;
      arb_pt    = 1'b0;
      if (hready) begin
         if (state == ST_LOCK)
            arb_pt = !hlock[owner_idx];
         else
            arb_pt = (htrans != HTRANS_SEQ) || force_arb || tenure_hit;
      end
      grant_nxt = pick_valid ? (4'b0001 << pick_idx) : 4'b0001;
   end

   // Arbitration state, grant and round-robin pointer
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state     <= ST_PARK;
         hgrant    <= 4'b0001;
         rr_ptr    <= 2'd0;
         force_arb <= 1'b0;
      end else if (err_first) begin
         // ERROR breaks any lock; rearbitrate on the next ready cycle
         if (state == ST_LOCK)
            state <= ST_OWN;
         force_arb <= 1'b1;
      end else if (arb_pt) begin
         force_arb <= 1'b0;
         hgrant    <= grant_nxt;
         if (!pick_valid) begin
            state <= ST_PARK;
         end else begin
            rr_ptr <= pick_idx;
            state  <= hlock[pick_idx] ? ST_LOCK : ST_OWN;
         end
      end
   end

`ifdef AHB_ARB_TENURE_LIMIT_EN
   localparam logic [7:0] TENURE_LIM = 8'(TENURE_MAX);

   logic [7:0] tenure_cnt;
   logic       others_req;

   assign others_req = |(hbusreq & ~hgrant);
   assign tenure_hit = (tenure_cnt >= TENURE_LIM);

   // Beats held by the owner while someone else waits; saturating
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)
         tenure_cnt <= 8'd0;
      else if (arb_pt && !err_first && (grant_nxt != hgrant))
         tenure_cnt <= 8'd0;
      else if (hready && others_req && (tenure_cnt < TENURE_LIM))
         tenure_cnt <= tenure_cnt + 8'd1;
   end
`else
   logic [7:0] unused_tenure_max;

   assign unused_tenure_max = 8'(TENURE_MAX);
   assign tenure_hit        = 1'b0;
`endif

   // Address-phase and data-phase master indices, locked-transfer flag
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hmaster      <= 2'd0;
         hmaster_data <= 2'd0;
         hmastlock    <= 1'b0;
      end else if (hready) begin
         hmaster      <= owner_idx;
         hmaster_data <= hmaster;
         hmastlock    <= hlock[owner_idx];
      end
   end

endmodule
